ysyx_23060236_ifu: RTL and testbench

YSYX_23060236_IFU -- requirements
Module: ysyx_23060236_ifu

---
 rtl/ysyx_23060236_ifu_pkg.sv | 24 ++
 rtl/ysyx_23060236_fetch_fifo.sv | 45 ++++
 rtl/ysyx_23060236_ifu.sv | 125 ++++++++++++
 tb/tb_ysyx_23060236_ifu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060236_ifu_pkg.sv
// Shared widths, reset vector, FSM encoding and fetch-queue entry layout for the IFU.
package ysyx_23060236_ifu_pkg;

    localparam int unsigned DATA_LEN = 32;
    localparam logic [DATA_LEN-1:0] RESET_PC = 32'h3000_0000;
    localparam int unsigned FQ_DEPTH = 2;
    localparam int unsigned FQ_PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned FQ_CNT_W = $clog2(FQ_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AR      = 3'd1,
        S_AR_KILL = 3'd2,
        S_R       = 3'd3,
        S_R_KILL  = 3'd4
    } ifu_state_e;

    typedef struct packed {
        logic [DATA_LEN-1:0] inst;
        logic [DATA_LEN-1:0] pc;
        logic [DATA_LEN-1:0] pred;
    } fq_entry_t;

endpackage

// File: rtl/ysyx_23060236_fetch_fifo.sv
// Small power-of-two fetch queue between the bus FSM and decode; flush empties it at once.
module ysyx_23060236_fetch_fifo
    import ysyx_23060236_ifu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic                i_flush,
    input  fq_entry_t           i_din,
    output fq_entry_t           o_dout,
    output logic [FQ_CNT_W-1:0] o_count
);

    fq_entry_t           r_mem [FQ_DEPTH];
    logic [FQ_PTR_W-1:0] r_rd;
    logic [FQ_PTR_W-1:0] r_wr;
    logic [FQ_CNT_W-1:0] r_count;

    // Flush wins over any same-cycle push or pop; pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/ysyx_23060236_ifu.sv
// Instruction fetch unit: one outstanding bus read, BTB-steered PC, redirect-aware kill states.
module ysyx_23060236_ifu
    import ysyx_23060236_ifu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    output logic [DATA_LEN-1:0] btb_araddr,
    input  logic [DATA_LEN-1:0] btb_rdata,
    output logic [DATA_LEN-1:0] ifu_araddr,
    output logic                ifu_arvalid,
    input  logic                ifu_arready,
    input  logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                ifu_rvalid,
    output logic                ifu_rready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_inst,
    output logic [DATA_LEN-1:0] out_pc,
    output logic [DATA_LEN-1:0] out_pred_pc,
    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc
);

    ifu_state_e          r_state;
    logic [DATA_LEN-1:0] r_pc;
    logic [DATA_LEN-1:0] r_req_pc;
    logic [DATA_LEN-1:0] r_req_pred;
    logic                r_arvalid;
    logic                r_rready;

    logic                w_push;
    logic                w_pop;
    logic [FQ_CNT_W-1:0] w_count;
    fq_entry_t           w_push_entry;
    fq_entry_t           w_head;

    assign btb_araddr  = r_pc;
    assign ifu_araddr  = r_req_pc;
    assign ifu_arvalid = r_arvalid;
    assign ifu_rready  = r_rready;

    assign w_push       = (r_state == S_R) && ifu_rvalid && !redirect_valid;
    assign w_pop        = out_valid && out_ready;
    assign w_push_entry = '{inst: ifu_rdata, pc: r_req_pc, pred: r_req_pred};

    assign out_valid   = (w_count != '0);
    assign out_inst    = w_head.inst;
    assign out_pc      = w_head.pc;
    assign out_pred_pc = w_head.pred;

    // Bus FSM; a redirect arriving mid-transaction diverts to a kill state that drains the response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_req_pred <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!redirect_valid && (w_count < FQ_CNT_W'(FQ_DEPTH))) begin
                        r_state    <= S_AR;
                        r_req_pc   <= r_pc;
                        r_req_pred <= btb_rdata;
                        r_arvalid  <= 1'b1;
                    end
                end
                S_AR: begin
                    if (ifu_arready) begin
                        r_state   <= redirect_valid ? S_R_KILL : S_R;
                        r_pc      <= r_req_pred;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end else if (redirect_valid) begin
                        r_state <= S_AR_KILL;
                    end
                end
                S_AR_KILL: begin
                    if (ifu_arready) begin
                        r_state   <= S_R_KILL;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                S_R: begin
                    if (ifu_rvalid) begin
                        r_state  <= S_IDLE;
                        r_rready <= 1'b0;
                    end else if (redirect_valid) begin
                        r_state <= S_R_KILL;
                    end
                end
                S_R_KILL: begin
                    if (ifu_rvalid) begin
                        r_state  <= S_IDLE;
                        r_rready <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
            // Later assignment overrides the predicted-PC advance above.
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end
        end
    end

    ysyx_23060236_fetch_fifo u_fetch_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_din   (w_push_entry),
        .o_dout  (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_ysyx_23060236_ifu.sv
// Directed bench for the IFU: BTB predicts pc+4, a latency-programmable memory, scoreboard on decode side.
module tb_ysyx_23060236_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;
    localparam logic [31:0] RD_PC  = 32'h3000_0100;
    localparam logic [31:0] KEY    = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] btb_araddr;
    logic [31:0] btb_rdata;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pred_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] ar_log[$];

    int          mem_lat = 0;
    logic        ar_block = 1'b0;
    logic        busy;
    int          dly;
    logic [31:0] maddr;

    always #5 clock = ~clock;

    ysyx_23060236_ifu dut (
        .clock          (clock),
        .reset          (reset),
        .btb_araddr     (btb_araddr),
        .btb_rdata      (btb_rdata),
        .ifu_araddr     (ifu_araddr),
        .ifu_arvalid    (ifu_arvalid),
        .ifu_arready    (ifu_arready),
        .ifu_rdata      (ifu_rdata),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rready     (ifu_rready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pred_pc    (out_pred_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    assign btb_rdata   = btb_araddr + 32'd4;
    assign ifu_arready = !busy && !ar_block;
    assign ifu_rvalid  = busy && (dly == 0);
    assign ifu_rdata   = maddr ^ KEY;

    // Memory slave: one request at a time, response after mem_lat extra cycles.
    always @(posedge clock) begin
        if (!reset) begin
            busy <= 1'b0;
            dly  <= 0;
        end else begin
            if (ifu_rvalid && ifu_rready) busy <= 1'b0;
            else if (busy && dly != 0) dly <= dly - 1;
            if (ifu_arvalid && ifu_arready) begin
                busy  <= 1'b1;
                maddr <= ifu_araddr;
                dly   <= mem_lat;
                ar_log.push_back(ifu_araddr);
            end
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Decode-side scoreboard: each accepted beat must match the next expected PC.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_beat observed=%h expected=none", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk(out_pc, e, "out_pc");
                chk(out_pred_pc, e + 32'd4, "out_pred_pc");
                chk(out_inst, e ^ KEY, "out_inst");
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut(input logic rdy, input int lat);
        reset = 1'b0;
        redirect_valid = 1'b0;
        ar_block = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        ar_log.delete();
        mem_lat = lat;
        out_ready = rdy;
        reset = 1'b1;
    endtask

    task automatic wait_log(input int n, input logic [31:0] expv, input string tag);
        for (int i = 0; i < 100 && ar_log.size() <= n; i++) tick();
        if (ar_log.size() > n) chk(ar_log[n], expv, tag);
        else fail_now(tag);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        out_ready = 1'b0;
        chk(32'(exp_q.size()), 32'd0, tag);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk(32'(ifu_arvalid), 32'd0, "rst_arvalid");
        chk(32'(ifu_rready), 32'd0, "rst_rready");
        chk(32'(out_valid), 32'd0, "rst_out_valid");
        chk(btb_araddr, RST_PC, "rst_btb_araddr");

        // Zero-wait streaming and first-fetch latency
        reset_dut(1'b1, 0);
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'd4);
        exp_q.push_back(RST_PC + 32'd8);
        tick();
        chk(32'(ifu_arvalid), 32'd1, "t1_arvalid");
        chk(ifu_araddr, RST_PC, "t1_araddr");
        tick();
        chk(32'(out_valid), 32'd0, "t1_lat2_valid");
        tick();
        chk(32'(out_valid), 32'd1, "t1_lat3_valid");
        drain("t1_drain");

        // Back-pressure: queue fills to depth and fetch stops
        reset_dut(1'b0, 0);
        for (int i = 0; i < 20; i++) tick();
        chk(32'(ar_log.size()), 32'd2, "t2_fetch_count");
        chk(32'(ifu_arvalid), 32'd0, "t2_arvalid_idle");
        chk(32'(out_valid), 32'd1, "t2_out_valid");
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'd4);
        exp_q.push_back(RST_PC + 32'd8);
        drain("t2_drain");
        if (ar_log.size() > 2) chk(ar_log[2], RST_PC + 32'd8, "t2_resume_addr");
        else fail_now("t2_resume_addr");

        // Redirect while waiting for read data
        reset_dut(1'b0, 2);
        tick();
        tick();
        chk(32'(ifu_rready), 32'd1, "t3_in_r");
        redirect_valid = 1'b1;
        redirect_pc = RD_PC;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        tick();
        chk(32'(out_valid), 32'd0, "t3_dropped");
        wait_log(1, RD_PC, "t3_next_addr");
        exp_q.push_back(RD_PC);
        drain("t3_drain");

        // Redirect during a stalled address phase
        reset_dut(1'b0, 0);
        ar_block = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = RD_PC;
        for (int i = 0; i < 3; i++) begin
            tick();
            redirect_valid = 1'b0;
            chk(32'(ifu_arvalid), 32'd1, "t4_arvalid_held");
            chk(ifu_araddr, RST_PC, "t4_araddr_held");
        end
        chk(btb_araddr, RD_PC, "t4_pc_redirected");
        ar_block = 1'b0;
        wait_log(1, RD_PC, "t4_next_addr");
        chk(ar_log[0], RST_PC, "t4_first_addr");
        chk(32'(out_valid), 32'd0, "t4_dropped");
        exp_q.push_back(RD_PC);
        drain("t4_drain");

        // Redirect coincident with rvalid, one entry queued and being popped
        reset_dut(1'b0, 0);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 50 && !found; i++) begin
                tick();
                if (ar_log.size() == 2 && ifu_rvalid && ifu_rready) found = 1'b1;
            end
            if (!found) fail_now("t5_reach_r");
        end
        exp_q.push_back(RST_PC);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = RD_PC;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        chk(32'(out_valid), 32'd0, "t5_no_push");
        chk(32'(exp_q.size()), 32'd0, "t5_popped");
        wait_log(2, RD_PC, "t5_next_addr");
        exp_q.push_back(RD_PC);
        drain("t5_drain");

        // Reset asserted mid read
        reset_dut(1'b0, 3);
        tick();
        tick();
        chk(32'(ifu_rready), 32'd1, "t6_in_r");
        reset = 1'b0;
        tick();
        chk(32'(ifu_arvalid), 32'd0, "t6_arvalid");
        chk(32'(out_valid), 32'd0, "t6_out_valid");
        chk(32'(ifu_rready), 32'd0, "t6_rready");
        tick();
        ar_log.delete();
        mem_lat = 0;
        reset = 1'b1;
        wait_log(0, RST_PC, "t6_first_addr");
        exp_q.push_back(RST_PC);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
